// File: rtl/ldl_pkg.sv
// Shared types for the ldl skid-buffered library blocks.
package ldl_pkg;

   // Occupancy of a one-register-plus-skid output stage.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } ldl_skid_state_e;

endpackage

// File: rtl/ldl_bin2hot_comb.sv
// Pure combinational binary-to-one-hot decoder with out-of-range flag.
module ldl_bin2hot_comb #(
   parameter int unsigned BIN_WIDTH = 4,
   parameter int unsigned HOT_WIDTH = 1 << BIN_WIDTH
) (
   input  logic [BIN_WIDTH-1:0] bin,
   output logic [HOT_WIDTH-1:0] hot,
   output logic                 oor
);

   // One bit per in-range index; out-of-range indices light nothing.
   always_comb begin
      hot = '0;
      for (int unsigned j = 0; j < HOT_WIDTH; j++) begin
         hot[j] = (bin == BIN_WIDTH'(j));
      end
      // Widen by one bit so HOT_WIDTH == 2**BIN_WIDTH is representable.
      oor = ({1'b0, bin} >= (BIN_WIDTH + 1)'(HOT_WIDTH));
   end

endmodule

// File: rtl/ldl_bin2hot_pipe_v1.sv
// Streaming binary-to-one-hot decoder, 1-cycle latency, full throughput.
// A skid entry keeps in_ready registered and free of any path from out_ready.
// Optional out_err port (out-of-range source index) enabled by LDL_BIN2HOT_ERR_EN.
module ldl_bin2hot_pipe_v1
   import ldl_pkg::*;
#(
   parameter int unsigned BIN_WIDTH = 4,
   parameter int unsigned HOT_WIDTH = 1 << BIN_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIN_WIDTH-1:0] in_bin,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [HOT_WIDTH-1:0] out_hot
`ifdef LDL_BIN2HOT_ERR_EN
   ,
   output logic                 out_err
`endif
);

   logic [HOT_WIDTH-1:0] dec_hot;
   logic                 dec_oor;

   ldl_bin2hot_comb #(
      .BIN_WIDTH(BIN_WIDTH),
      .HOT_WIDTH(HOT_WIDTH)
   ) u_dec (
      .bin(in_bin),
      .hot(dec_hot),
      .oor(dec_oor)
   );

   ldl_skid_state_e      state_q, state_d;
   logic                 out_valid_q, out_valid_d;
   logic                 in_ready_q, in_ready_d;
   logic [HOT_WIDTH-1:0] out_hot_q, out_hot_d;
   logic [HOT_WIDTH-1:0] skid_hot_q, skid_hot_d;
`ifdef LDL_BIN2HOT_ERR_EN
   logic                 out_err_q, out_err_d;
   logic                 skid_err_q, skid_err_d;
`endif

   logic in_fire, out_fire;
   assign in_fire  = in_valid && in_ready_q;
   assign out_fire = out_valid_q && out_ready;

   // Decoder sanity: an out-of-range index must never produce a set bit.
   always_comb begin
      if (dec_oor) begin
         assert (dec_hot == '0);
      end
   end

   // Next-state for the occupancy FSM, output register and skid entry.
   always_comb begin
      state_d    = state_q;
      out_hot_d  = out_hot_q;
      skid_hot_d = skid_hot_q;
`ifdef LDL_BIN2HOT_ERR_EN
      out_err_d  = out_err_q;
      skid_err_d = skid_err_q;
`endif
      unique case (state_q)
         EMPTY: begin
            if (in_fire) begin
               state_d   = ONE;
               out_hot_d = dec_hot;
`ifdef LDL_BIN2HOT_ERR_EN
               out_err_d = dec_oor;
`endif
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               out_hot_d = dec_hot;
`ifdef LDL_BIN2HOT_ERR_EN
               out_err_d = dec_oor;
`endif
            end else if (in_fire) begin
               state_d    = TWO;
               skid_hot_d = dec_hot;
`ifdef LDL_BIN2HOT_ERR_EN
               skid_err_d = dec_oor;
`endif
            end else if (out_fire) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            // in_ready is low here, so only the output side can move.
            if (out_fire) begin
               state_d   = ONE;
               out_hot_d = skid_hot_q;
`ifdef LDL_BIN2HOT_ERR_EN
               out_err_d = skid_err_q;
`endif
            end
         end
         default: state_d = EMPTY;
      endcase
      out_valid_d = (state_d != EMPTY);
      in_ready_d  = (state_d != TWO);
   end

   // State and registered handshake outputs; reset discards both entries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         out_hot_q   <= '0;
         skid_hot_q  <= '0;
`ifdef LDL_BIN2HOT_ERR_EN
         out_err_q   <= 1'b0;
         skid_err_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         out_hot_q   <= out_hot_d;
         skid_hot_q  <= skid_hot_d;
`ifdef LDL_BIN2HOT_ERR_EN
         out_err_q   <= out_err_d;
         skid_err_q  <= skid_err_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_hot   = out_hot_q;
`ifdef LDL_BIN2HOT_ERR_EN
   assign out_err   = out_err_q;
`endif

endmodule

// File: tb/tb_ldl_bin2hot_pipe_v1.sv
// Self-checking bench for ldl_bin2hot_pipe_v1 (16-wide instance plus a 10-wide instance).
module tb_ldl_bin2hot_pipe_v1;

   logic        clk;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [3:0]  in_bin;
   logic [15:0] out_hot;
`ifdef LDL_BIN2HOT_ERR_EN
   logic        out_err;
`endif

   logic        in2_valid, in2_ready, out2_valid, out2_ready;
   logic [3:0]  in2_bin;
   logic [9:0]  out2_hot;
`ifdef LDL_BIN2HOT_ERR_EN
   logic        out2_err;
`endif

   ldl_bin2hot_pipe_v1 #(
      .BIN_WIDTH(4),
      .HOT_WIDTH(16)
   ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_bin(in_bin),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_hot(out_hot)
`ifdef LDL_BIN2HOT_ERR_EN
      ,
      .out_err(out_err)
`endif
   );

   ldl_bin2hot_pipe_v1 #(
      .BIN_WIDTH(4),
      .HOT_WIDTH(10)
   ) u_dut10 (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in2_valid),
      .in_ready(in2_ready),
      .in_bin(in2_bin),
      .out_valid(out2_valid),
      .out_ready(out2_ready),
      .out_hot(out2_hot)
`ifdef LDL_BIN2HOT_ERR_EN
      ,
      .out_err(out2_err)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Advance one clock; sampling and driving happen 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        iv;
      logic [3:0]  bin;
      logic        ordy;
      logic        ev;
      logic        er;
      logic [15:0] eh;
   } vec_t;

   vec_t vecs[14];

   logic [15:0] q[$];
   logic [15:0] prev_hot;
   logic        prev_stall;
   int unsigned nout;

   initial begin
      // Inputs applied for one edge; expected outputs observed after that edge.
      vecs[0]  = '{1'b1, 4'd0,  1'b1, 1'b1, 1'b1, 16'h0001};
      vecs[1]  = '{1'b1, 4'd5,  1'b1, 1'b1, 1'b1, 16'h0020};
      vecs[2]  = '{1'b1, 4'd15, 1'b1, 1'b1, 1'b1, 16'h8000};
      vecs[3]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 16'h8000};
      vecs[4]  = '{1'b1, 4'd3,  1'b0, 1'b1, 1'b1, 16'h0008};
      vecs[5]  = '{1'b1, 4'd7,  1'b0, 1'b1, 1'b0, 16'h0008};
      vecs[6]  = '{1'b1, 4'd9,  1'b0, 1'b1, 1'b0, 16'h0008};
      vecs[7]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 16'h0080};
      vecs[8]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 16'h0080};
      vecs[9]  = '{1'b1, 4'd2,  1'b0, 1'b1, 1'b1, 16'h0004};
      vecs[10] = '{1'b1, 4'd14, 1'b1, 1'b1, 1'b1, 16'h4000};
      vecs[11] = '{1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 16'h4000};
      vecs[12] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 16'h0002};
      vecs[13] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 16'h0002};

      // Reset held with in_valid high must leave everything idle.
      rst_n      = 1'b0;
      in_valid   = 1'b1;
      in_bin     = 4'd5;
      out_ready  = 1'b0;
      in2_valid  = 1'b0;
      in2_bin    = 4'd0;
      out2_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset out_hot", 32'(out_hot), 32'h0000);
`ifdef LDL_BIN2HOT_ERR_EN
      chk("reset out_err", 32'(out_err), 32'd0);
`endif
      in_valid = 1'b0;
      rst_n    = 1'b1;
      step();
      chk("release out_valid", 32'(out_valid), 32'd0);

      // Streaming and backpressure vectors.
      foreach (vecs[i]) begin
         in_valid  = vecs[i].iv;
         in_bin    = vecs[i].bin;
         out_ready = vecs[i].ordy;
         step();
         chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
         chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].er));
         chk($sformatf("vec%0d out_hot", i), 32'(out_hot), 32'(vecs[i].eh));
      end
      in_valid = 1'b0;

      // Out-of-range index on the 10-wide instance still transfers, with hot = 0.
      in2_valid = 1'b1;
      in2_bin   = 4'd12;
      step();
      chk("oor out_valid", 32'(out2_valid), 32'd1);
      chk("oor out_hot", 32'(out2_hot), 32'h000);
`ifdef LDL_BIN2HOT_ERR_EN
      chk("oor out_err", 32'(out2_err), 32'd1);
`endif
      in2_bin = 4'd9;
      step();
      chk("top in-range out_hot", 32'(out2_hot), 32'h200);
`ifdef LDL_BIN2HOT_ERR_EN
      chk("top in-range out_err", 32'(out2_err), 32'd0);
`endif
      in2_valid = 1'b0;
      step();
      chk("w10 drain out_valid", 32'(out2_valid), 32'd0);

      // Fill to TWO, then reset asynchronously mid-cycle.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_bin    = 4'd4;
      step();
      in_bin = 4'd6;
      step();
      chk("two in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst out_valid", 32'(out_valid), 32'd0);
      chk("async rst in_ready", 32'(in_ready), 32'd1);
      chk("async rst out_hot", 32'(out_hot), 32'h0000);
      step();
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      step();
      chk("post rst out_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      in_bin   = 4'd1;
      step();
      in_valid = 1'b0;
      nout     = 0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) begin
            nout++;
            chk("post rst out_hot", 32'(out_hot), 32'h0002);
         end
         step();
      end
      chk("post rst vector count", nout, 32'd1);

      // Random valid/ready against a scoreboard queue.
      q.delete();
      prev_stall = 1'b0;
      prev_hot   = '0;
      for (int c = 0; c < 10000; c++) begin
         chk("rand out_valid", 32'(out_valid), 32'(q.size() != 0));
         chk("rand in_ready", 32'(in_ready), 32'(q.size() < 2));
         chk("rand popcount", 32'($countones(out_hot) <= 1), 32'd1);
         if (prev_stall) begin
            chk("rand stall hold", 32'(out_hot), 32'(prev_hot));
         end
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_bin    = 4'($urandom_range(0, 15));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("rand spurious output", 32'd1, 32'd0);
            end else begin
               chk("rand fifo order", 32'(out_hot), 32'(q[0]));
               chk("rand one-hot", 32'($countones(out_hot)), 32'd1);
               void'(q.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(16'd1 << in_bin);
         end
         prev_stall = out_valid && !out_ready;
         prev_hot   = out_hot;
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
